// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-RAM arbiter between the core load/store port and the
// external burst requester.
package dmem_arb_pkg;

  localparam int unsigned RAM_AW = 10;
  localparam int unsigned DW     = 32;

  typedef enum logic {ARB, EXT_LOCK} arb_state_t;
  typedef enum logic {GNT_CORE, GNT_EXT} grant_t;

  // One external beat as presented on the x_* port
  typedef struct packed {
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          last;
  } ext_beat_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick: a lone requester wins, a tie goes opposite to last_grant.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  grant_t     last_grant,
  output grant_t     grant
);

  // req[0] = core, req[1] = ext
  always_comb begin
    grant = GNT_CORE;
    if (req == 2'b10) begin
      grant = GNT_EXT;
    end else if (req == 2'b11) begin
      if (last_grant == GNT_EXT) grant = GNT_CORE;
      else                       grant = GNT_EXT;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the core load/store port and an external burst
// requester: round-robin per cycle, burst lock with beat limit and idle timeout.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned IDLE_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DW-1:0]     c_daddr,
  input  logic [DW-1:0]     c_ddata_w,
  input  logic              c_d_w,
  input  logic              c_d_r,
  output logic [DW-1:0]     c_ddata_r,
  output logic              c_stall,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic              x_we,
  input  logic [DW-1:0]     x_addr,
  input  logic [DW-1:0]     x_wdata,
  input  logic              x_last,
  output logic [DW-1:0]     x_rdata,
  output logic              x_rvalid,
  output logic              x_err,
  output logic              m_wren,
  output logic [RAM_AW-1:0] m_addr,
  output logic [DW-1:0]     m_data_in,
  input  logic [DW-1:0]     m_data_out
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);

  arb_state_t    state;
  grant_t        last_grant;
  grant_t        arb_grant;
  logic [BW-1:0] beat_cnt;
  logic [IW-1:0] idle_cnt;
  ext_beat_t     xb;
  logic          core_req;
  logic          core_gnt;
  logic          ext_sel;
  logic          beat;
  logic          misaligned;
  logic          unused_addr_bits;

  assign xb = '{we: x_we, addr: x_addr, wdata: x_wdata, last: x_last};

  // Address bits above the RAM window wrap silently
  assign unused_addr_bits = ^{c_daddr[DW-1:RAM_AW+2], c_daddr[1:0], xb.addr[DW-1:RAM_AW+2]};

  rr_arb2 u_rr (
    .req        ({x_valid, core_req}),
    .last_grant (last_grant),
    .grant      (arb_grant)
  );

  // Grant decode and RAM mux; everything is forced idle while reset is high
  always_comb begin
    core_req   = c_d_r | c_d_w;
    misaligned = (xb.addr[1:0] != 2'b00);
    core_gnt   = 1'b0;
    ext_sel    = 1'b0;
    if (!reset) begin
      if (state == EXT_LOCK) begin
        ext_sel = 1'b1;
      end else if (core_req && (!x_valid || arb_grant == GNT_CORE)) begin
        core_gnt = 1'b1;
      end else if (x_valid) begin
        ext_sel = 1'b1;
      end
    end
    beat      = ext_sel & x_valid;
    x_ready   = ext_sel;
    c_stall   = core_req & ~core_gnt;
    c_ddata_r = m_data_out;
    m_wren    = 1'b0;
    m_addr    = '0;
    m_data_in = '0;
    if (core_gnt) begin
      m_wren    = c_d_w;
      m_addr    = c_daddr[RAM_AW+1:2];
      m_data_in = c_ddata_w;
    end else if (beat) begin
      m_wren    = xb.we & ~misaligned;
      m_addr    = xb.addr[RAM_AW+1:2];
      m_data_in = xb.wdata;
    end
  end

  // Arbitration state, burst/idle counters and the registered ext read-response path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB;
      last_grant <= GNT_EXT;
      beat_cnt   <= '0;
      idle_cnt   <= '0;
      x_rdata    <= '0;
      x_rvalid   <= 1'b0;
      x_err      <= 1'b0;
    end else begin
      x_rvalid <= beat & ~xb.we;
      x_err    <= beat & misaligned;
      if (beat && !xb.we) begin
        x_rdata <= misaligned ? '0 : m_data_out;
      end
      unique case (state)
        ARB: begin
          if (core_gnt) begin
            last_grant <= GNT_CORE;
          end else if (beat) begin
            last_grant <= GNT_EXT;
            if (!xb.last && MAX_BURST > 1) begin
              state    <= EXT_LOCK;
              beat_cnt <= BW'(1);
              idle_cnt <= '0;
            end
          end
        end
        EXT_LOCK: begin
          if (beat) begin
            if (xb.last || beat_cnt == BW'(MAX_BURST - 1)) begin
              state      <= ARB;
              last_grant <= GNT_EXT;
              beat_cnt   <= '0;
              idle_cnt   <= '0;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
              idle_cnt <= '0;
            end
          end else if (idle_cnt == IW'(IDLE_TIMEOUT - 1)) begin
            state      <= ARB;
            last_grant <= GNT_EXT;
            beat_cnt   <= '0;
            idle_cnt   <= '0;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural RAM, reference memory image and a
// scoreboard of expected ext read/error responses.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] c_daddr, c_ddata_w, c_ddata_r;
  logic        c_d_w, c_d_r, c_stall;
  logic        x_valid, x_ready, x_we, x_last, x_rvalid, x_err;
  logic [31:0] x_addr, x_wdata, x_rdata;
  logic        m_wren;
  logic [9:0]  m_addr;
  logic [31:0] m_data_in, m_data_out;

  logic [31:0] ram     [0:1023];
  logic [31:0] exp_mem [0:1023];
  logic        preload = 1'b1;

  typedef struct {
    logic        rv;
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  dmem_arbiter #(.MAX_BURST(8), .IDLE_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .c_daddr(c_daddr), .c_ddata_w(c_ddata_w), .c_d_w(c_d_w), .c_d_r(c_d_r),
    .c_ddata_r(c_ddata_r), .c_stall(c_stall),
    .x_valid(x_valid), .x_ready(x_ready), .x_we(x_we), .x_addr(x_addr),
    .x_wdata(x_wdata), .x_last(x_last), .x_rdata(x_rdata), .x_rvalid(x_rvalid),
    .x_err(x_err),
    .m_wren(m_wren), .m_addr(m_addr), .m_data_in(m_data_in), .m_data_out(m_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hB0B0_0000 + 32'(i);
  endfunction

  assign m_data_out = ram[m_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload) begin
      for (int i = 0; i < 1024; i++) ram[i] <= pat(i);
    end else if (m_wren) begin
      ram[m_addr] <= m_data_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response monitor: each expected entry is due exactly one cycle after its beat
  always @(negedge clk) begin
    if (sbq.size() != 0 && sbq[0].due == cyc) begin
      mon_e = sbq.pop_front();
      check("x_rvalid", 32'(x_rvalid), 32'(mon_e.rv));
      check("x_err", 32'(x_err), 32'(mon_e.err));
      if (mon_e.rv) check("x_rdata", x_rdata, mon_e.data);
    end else if (x_rvalid || x_err) begin
      check("spurious_pulse", 32'({x_rvalid, x_err}), 32'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_core();
    c_d_w = 1'b0; c_d_r = 1'b0; c_daddr = '0; c_ddata_w = '0;
  endtask

  task automatic idle_ext();
    x_valid = 1'b0; x_we = 1'b0; x_addr = '0; x_wdata = '0; x_last = 1'b0;
  endtask

  task automatic core(input logic we, input logic [31:0] a, input logic [31:0] d);
    c_d_w = we; c_d_r = ~we; c_daddr = a; c_ddata_w = d;
  endtask

  task automatic ext(input logic we, input logic [31:0] a, input logic [31:0] d, input logic last);
    x_valid = 1'b1; x_we = we; x_addr = a; x_wdata = d; x_last = last;
  endtask

  task automatic push_rd(input logic [31:0] a);
    logic mis;
    mis = (a[1:0] != 2'b00);
    sbq.push_back('{rv: 1'b1, err: mis, data: (mis ? 32'h0 : exp_mem[a[11:2]]), due: cyc + 1});
  endtask

  task automatic push_err();
    sbq.push_back('{rv: 1'b0, err: 1'b1, data: 32'h0, due: cyc + 1});
  endtask

  initial begin
    reset = 1'b1;
    idle_core();
    idle_ext();
    for (int i = 0; i < 1024; i++) exp_mem[i] = pat(i);

    // Reset: outputs quiet, core stalled while requesting
    c_d_w = 1'b1; c_d_r = 1'b1; x_valid = 1'b1; x_we = 1'b1;
    tick();
    check("rst_c_stall", 32'(c_stall), 32'(1));
    check("rst_x_ready", 32'(x_ready), 32'(0));
    check("rst_m_wren", 32'(m_wren), 32'(0));
    check("rst_x_rvalid", 32'(x_rvalid), 32'(0));
    check("rst_x_err", 32'(x_err), 32'(0));
    check("rst_x_rdata", x_rdata, 32'h0);
    tick();
    preload = 1'b0;
    idle_core();
    idle_ext();
    reset = 1'b0;
    tick();

    // 1: core store then load, same-cycle data, high address bits wrap
    core(1'b1, 32'h10, 32'hCAFE_0001);
    #2;
    check("t1_w_stall", 32'(c_stall), 32'(0));
    check("t1_m_wren", 32'(m_wren), 32'(1));
    check("t1_m_addr", 32'(m_addr), 32'h4);
    check("t1_m_data_in", m_data_in, 32'hCAFE_0001);
    exp_mem[4] = 32'hCAFE_0001;
    tick();
    core(1'b0, 32'hFFFF_F010, 32'h0);
    #2;
    check("t1_r_stall", 32'(c_stall), 32'(0));
    check("t1_r_data", c_ddata_r, exp_mem[4]);
    tick();

    // 2: single ext write leaves last_grant=EXT, then contention alternates
    idle_core();
    ext(1'b1, 32'h80, 32'h1111_2222, 1'b1);
    #2;
    check("t2_xw_ready", 32'(x_ready), 32'(1));
    check("t2_xw_wren", 32'(m_wren), 32'(1));
    check("t2_xw_addr", 32'(m_addr), 32'h20);
    exp_mem[32'h20] = 32'h1111_2222;
    tick();
    core(1'b0, 32'h10, 32'h0);
    ext(1'b0, 32'h40, 32'h0, 1'b1);
    #2;
    check("t2_core_first", 32'(c_stall), 32'(0));
    check("t2_ext_held", 32'(x_ready), 32'(0));
    check("t2_core_data", c_ddata_r, exp_mem[4]);
    tick();
    #2;
    check("t2_ext_second", 32'(x_ready), 32'(1));
    check("t2_core_stalled", 32'(c_stall), 32'(1));
    push_rd(32'h40);
    tick();

    // 3: 4-beat locked read burst with core waiting
    idle_ext();
    core(1'b0, 32'h10, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      ext(1'b0, 32'h40 + 32'(4 * i), 32'h0, i == 3);
      #2;
      check("t3_stall", 32'(c_stall), 32'(1));
      check("t3_ready", 32'(x_ready), 32'(1));
      push_rd(32'h40 + 32'(4 * i));
      tick();
    end
    ext(1'b0, 32'h60, 32'h0, 1'b1);
    #2;
    check("t3_core_after_last", 32'(c_stall), 32'(0));
    check("t3_ext_held", 32'(x_ready), 32'(0));
    tick();
    #2;
    check("t3_ext_retry", 32'(x_ready), 32'(1));
    push_rd(32'h60);
    tick();

    // 4: 10 write beats without x_last; forced release after the 8th
    idle_ext();
    tick();
    for (int i = 0; i < 10; i++) begin
      ext(1'b1, 32'h100 + 32'(4 * i), 32'hD000_0000 + 32'(i), 1'b0);
      if (i == 8) begin
        #2;
        check("t4_release_core", 32'(c_stall), 32'(0));
        check("t4_release_ext", 32'(x_ready), 32'(0));
        tick();
      end
      #2;
      check("t4_ready", 32'(x_ready), 32'(1));
      check("t4_stall", 32'(c_stall), 32'(1));
      check("t4_wren", 32'(m_wren), 32'(1));
      exp_mem[32'h40 + i] = 32'hD000_0000 + 32'(i);
      tick();
    end

    // 5: idle inside the lock until the timeout releases it
    idle_ext();
    core(1'b0, 32'h108, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #2;
      check("t5_idle_stall", 32'(c_stall), 32'(1));
      check("t5_idle_ready", 32'(x_ready), 32'(1));
      tick();
    end
    #2;
    check("t5_core_after_timeout", 32'(c_stall), 32'(0));
    check("t5_core_data", c_ddata_r, exp_mem[32'h42]);
    tick();

    // 6: misaligned beats flag x_err and never write the RAM
    idle_core();
    ext(1'b1, 32'h22, 32'hBAD0_BAD0, 1'b1);
    #2;
    check("t6_mis_ready", 32'(x_ready), 32'(1));
    check("t6_mis_wren", 32'(m_wren), 32'(0));
    push_err();
    tick();
    ext(1'b0, 32'h41, 32'h0, 1'b1);
    #2;
    check("t6_misrd_ready", 32'(x_ready), 32'(1));
    push_rd(32'h41);
    tick();
    idle_ext();
    core(1'b0, 32'h20, 32'h0);
    #2;
    check("t6_ram_unchanged", c_ddata_r, exp_mem[8]);
    tick();

    // Reset in the middle of a locked burst
    idle_core();
    ext(1'b1, 32'h200, 32'h1234_5678, 1'b0);
    #2;
    check("rb_first_ready", 32'(x_ready), 32'(1));
    exp_mem[32'h80] = 32'h1234_5678;
    tick();
    ext(1'b0, 32'h44, 32'h0, 1'b0);
    #2;
    check("rb_lock_ready", 32'(x_ready), 32'(1));
    push_rd(32'h44);
    tick();
    ext(1'b1, 32'h48, 32'h0BAD_0BAD, 1'b0);
    #6;
    reset = 1'b1;
    #1;
    check("rb_rst_ready", 32'(x_ready), 32'(0));
    check("rb_rst_wren", 32'(m_wren), 32'(0));
    check("rb_rst_rvalid", 32'(x_rvalid), 32'(0));
    tick();
    reset = 1'b0;
    core(1'b0, 32'h48, 32'h0);
    ext(1'b0, 32'h4C, 32'h0, 1'b1);
    #2;
    check("rb_arb_core", 32'(c_stall), 32'(0));
    check("rb_arb_ext_held", 32'(x_ready), 32'(0));
    check("rb_no_write", c_ddata_r, exp_mem[32'h12]);
    tick();
    #2;
    check("rb_ext_next", 32'(x_ready), 32'(1));
    push_rd(32'h4C);
    tick();
    idle_ext();
    core(1'b0, 32'h200, 32'h0);
    #2;
    check("rb_burst_write", c_ddata_r, 32'h1234_5678);
    tick();

    idle_core();
    repeat (3) tick();
    check("sb_empty", 32'(sbq.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
